quadrature_generator: RTL and testbench

Synthesises quadrature ChannelA/ChannelB waveforms for a commanded signed number of edges at a programmable edge rate. It is the transmit-side counterpart of the quadrature edge counter. Its uses are hardware-in-the-loop motor/encoder emulation and loopback self-test of the counter path. It sits on the same fabric clock as the counter, driven by a control register block.

---
 rtl/quadrature_generator_if.sv | 24 ++
 rtl/quadrature_generator.sv | 115 +++++++++++
 tb/tb_quadrature_generator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/quadrature_generator_if.sv
// Command/status bundle between the control register block and the quadrature generator.
interface quadrature_generator_if #(
    parameter int COUNT_WIDTH = 32,
    parameter int DIV_WIDTH   = 16
);
    logic                          Start;
    logic signed [COUNT_WIDTH-1:0] Steps;
    logic        [DIV_WIDTH-1:0]   Period;
    logic                          Stop;
    logic                          ChannelA;
    logic                          ChannelB;
    logic                          Busy;
    logic                          Done;
    logic signed [COUNT_WIDTH-1:0] Position;

    modport master (
        output Start, Steps, Period, Stop,
        input  ChannelA, ChannelB, Busy, Done, Position
    );
    modport slave (
        input  Start, Steps, Period, Stop,
        output ChannelA, ChannelB, Busy, Done, Position
    );
endinterface

// File: rtl/quadrature_generator.sv
// Emits a signed number of quadrature edges at a programmable edge rate; A leads B when forward.
module quadrature_generator #(
    parameter int COUNT_WIDTH = 32,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    quadrature_generator_if.slave  bus
);
    localparam logic [COUNT_WIDTH-1:0] C_ONE = COUNT_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0]   D_ONE = DIV_WIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             phase_q, phase_d;
    logic [1:0]             ab_q, ab_d;
    logic                   dir_q, dir_d;
    logic                   done_q, done_d;
    logic [COUNT_WIDTH-1:0] pos_q, pos_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0]   per_q, per_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [COUNT_WIDTH-1:0] steps_u, steps_mag;
    logic [DIV_WIDTH-1:0]   per_in;

    // Gray mapping chosen so that (new A xor old B) is 1 for forward steps.
    function automatic logic [1:0] phase2ab(input logic [1:0] p);
        case (p)
            2'd0:    phase2ab = 2'b00;
            2'd1:    phase2ab = 2'b10;
            2'd2:    phase2ab = 2'b11;
            default: phase2ab = 2'b01;
        endcase
    endfunction

    // Magnitude is unsigned so the most negative Steps value is a legal count.
    assign steps_u   = bus.Steps;
    assign steps_mag = steps_u[COUNT_WIDTH-1] ? (~steps_u + C_ONE) : steps_u;
    assign per_in    = (bus.Period == '0) ? D_ONE : bus.Period;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        pos_d   = pos_q;
        rem_d   = rem_q;
        per_d   = per_q;
        div_d   = div_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    if (steps_u == '0) begin
                        done_d = 1'b1;
                    end else begin
                        dir_d   = steps_u[COUNT_WIDTH-1];
                        rem_d   = steps_mag;
                        per_d   = per_in;
                        div_d   = per_in - D_ONE;
                        state_d = RUN;
                    end
                end
            end
            default: begin
                if (bus.Stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (div_q != '0) begin
                    div_d = div_q - D_ONE;
                end else begin
                    phase_d = dir_q ? (phase_q - 2'd1) : (phase_q + 2'd1);
                    pos_d   = dir_q ? (pos_q - C_ONE) : (pos_q + C_ONE);
                    rem_d   = rem_q - C_ONE;
                    div_d   = per_q - D_ONE;
                    if (rem_q == C_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
        ab_d = phase2ab(phase_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            ab_q    <= 2'b00;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            pos_q   <= '0;
            rem_q   <= '0;
            per_q   <= D_ONE;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ab_q    <= ab_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            per_q   <= per_d;
            div_q   <= div_d;
        end
    end

    assign bus.ChannelA = ab_q[1];
    assign bus.ChannelB = ab_q[0];
    assign bus.Busy     = (state_q == RUN);
    assign bus.Done     = done_q;
    assign bus.Position = pos_q;
endmodule

// File: tb/tb_quadrature_generator.sv
// Directed checks of the quadrature generator with an in-bench quadrature decoder.
module tb_quadrature_generator;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    int   edge_cnt = 0;
    int   done_cnt = 0;
    int   viol     = 0;
    int   dec      = 0;
    logic [1:0] prev_ab = 2'b00;

    always #5 clk = ~clk;

    quadrature_generator_if #(.COUNT_WIDTH(32), .DIV_WIDTH(16)) bus ();
    quadrature_generator #(.COUNT_WIDTH(32), .DIV_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wire [1:0] ab = {bus.ChannelA, bus.ChannelB};

    // Decoder: direction term is (new A xor old B); forward counts up.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            prev_ab = 2'b00;
            dec     = 0;
        end else begin
            if (bus.Done) done_cnt++;
            if (ab != prev_ab) begin
                edge_cnt++;
                if (ab[1] != prev_ab[1] && ab[0] != prev_ab[0]) viol++;
                dec = dec + ((ab[1] ^ prev_ab[0]) ? 1 : -1);
            end
            prev_ab = ab;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic signed [31:0] s, input logic [15:0] p);
        bus.Start  = 1'b1;
        bus.Steps  = s;
        bus.Period = p;
        tick();
        bus.Start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!bus.Done && n < budget) begin
            tick();
            n++;
        end
        chk("wait_done_timeout", longint'(bus.Done), 1);
    endtask

    logic [1:0] t2_ab [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
    logic [1:0] t3_ab [3] = '{2'b00, 2'b01, 2'b11};
    logic [1:0] t9_ab [3] = '{2'b01, 2'b11, 2'b10};

    initial begin
        int d0, e0;
        longint p0;
        logic [1:0] a0;
        reset      = 1'b0;
        bus.Start  = 1'b0;
        bus.Steps  = '0;
        bus.Period = '0;
        bus.Stop   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ab", ab, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_pos", bus.Position, 0);
        reset = 1'b1;

        // Idle with a stray Stop: nothing happens.
        repeat (5) tick();
        bus.Stop = 1'b1;
        repeat (5) tick();
        bus.Stop = 1'b0;
        chk("idle_ab", ab, 0);
        chk("idle_busy", bus.Busy, 0);
        chk("idle_done", bus.Done, 0);
        chk("idle_pos", bus.Position, 0);
        chk("idle_stop_done", done_cnt, 0);

        // +5 @ Period 4.
        d0 = done_cnt;
        start(32'sd5, 16'd4);
        chk("t2_busy", bus.Busy, 1);
        repeat (3) tick();
        chk("t2_latency", ab, 0);
        tick();
        chk("t2_ab1", ab, t2_ab[0]);
        chk("t2_pos1", bus.Position, 1);
        for (int k = 1; k < 5; k++) begin
            repeat (4) tick();
            chk("t2_ab", ab, t2_ab[k]);
            chk("t2_pos", bus.Position, k + 1);
        end
        chk("t2_busy_end", bus.Busy, 0);
        chk("t2_done", bus.Done, 1);
        tick();
        chk("t2_done_clr", bus.Done, 0);
        chk("t2_done_once", done_cnt - d0, 1);

        // -3 @ Period 0 (treated as 1), continuing from phase 1.
        start(-32'sd3, 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_ab", ab, t3_ab[k]);
            chk("t3_pos", bus.Position, 4 - k);
        end
        chk("t3_done", bus.Done, 1);
        chk("t3_busy", bus.Busy, 0);

        // Steps = 0: immediate Done, no activity.
        tick();
        a0 = ab;
        e0 = edge_cnt;
        start(32'sd0, 16'd7);
        chk("t4_done", bus.Done, 1);
        chk("t4_busy", bus.Busy, 0);
        tick();
        chk("t4_done_clr", bus.Done, 0);
        chk("t4_ab", ab, a0);
        chk("t4_edges", edge_cnt - e0, 0);

        // Start during RUN is ignored.
        e0 = edge_cnt;
        start(32'sd4, 16'd2);
        tick();
        bus.Start = 1'b1; bus.Steps = 32'sd100; bus.Period = 16'd1;
        tick();
        bus.Start = 1'b0;
        wait_done(50);
        chk("t5_pos", bus.Position, 6);
        tick();
        chk("t5_edges", edge_cnt - e0, 4);

        // Stop on the 50th edge cycle of +100 @ Period 3.
        e0 = edge_cnt;
        d0 = done_cnt;
        start(32'sd100, 16'd3);
        repeat (149) tick();
        bus.Stop = 1'b1;
        tick();
        bus.Stop = 1'b0;
        chk("t6_busy", bus.Busy, 0);
        chk("t6_done", bus.Done, 1);
        chk("t6_pos", bus.Position, 55);
        repeat (4) tick();
        chk("t6_edges", edge_cnt - e0, 49);
        chk("t6_done_once", done_cnt - d0, 1);
        chk("t6_pos_hold", bus.Position, 55);

        // Most negative Steps is a legal, long reverse run.
        start(32'sh80000000, 16'd1);
        repeat (3) tick();
        chk("t7_busy", bus.Busy, 1);
        chk("t7_pos", bus.Position, 52);
        bus.Stop = 1'b1;
        tick();
        bus.Stop = 1'b0;
        chk("t7_done", bus.Done, 1);

        // Asynchronous reset mid-run.
        tick();
        d0 = done_cnt;
        start(32'sd10, 16'd1);
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        chk("t8_ab", ab, 0);
        chk("t8_busy", bus.Busy, 0);
        chk("t8_done", bus.Done, 0);
        chk("t8_pos", bus.Position, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        chk("t8_busy_after", bus.Busy, 0);
        chk("t8_no_done", done_cnt - d0, 0);

        // Reverse from fresh reset.
        start(-32'sd3, 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t9_ab", ab, t9_ab[k]);
            chk("t9_pos", bus.Position, -(k + 1));
        end
        tick();
        chk("t9_dec", dec, -3);

        // Loopback through the in-bench decoder, back-to-back commands.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        start(32'sd1000, 16'd2);
        wait_done(2100);
        start(-32'sd400, 16'd1);
        wait_done(500);
        repeat (3) tick();
        chk("t10_pos", bus.Position, 600);
        chk("t10_dec", dec, 600);
        chk("t10_one_chan", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
